// File: rtl/sysid_pkg.sv
// Shared state encoding and default expected values for the
// system ID / build timestamp check sequencer.
package sysid_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_CMD  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_CMD  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [31:0] DEF_EXPECTED_ID    = 32'h0000_0001;
    localparam logic [31:0] DEF_EXPECTED_TS    = 32'h5302_A009;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/sysid_check_sequencer_if.sv
// Avalon-MM read-only master bundle used by the check sequencer.
interface sysid_check_sequencer_if;

    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );

endinterface

// File: rtl/sysid_rd_timer.sv
// Per-transaction cycle counter; flags when a read has used its budget.
module sysid_rd_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Saturates so a stuck transaction can never wrap back under LIMIT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != 8'hFF)) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count >= LIMIT);

endmodule

// File: rtl/sysid_check_sequencer.sv
// Reads the system ID and build timestamp over Avalon-MM and
// compares them with the values this image was built against.
module sysid_check_sequencer
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TS,
    parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    id_ok,
    output logic                    ts_ok,
    output logic                    timeout_err,
    output logic [31:0]             id_value,
    output logic [31:0]             ts_value,
    sysid_check_sequencer_if.master avm
);

    state_t state;
    state_t state_nx;

    logic address;
    logic id_to;
    logic ts_to;
    logic in_cmd;
    logic in_wait;
    logic id_phase;
    logic accepted;
    logic hit;
    logic miss;
    logic expired;
    logic tmr_clear;
    logic tmr_en;

    assign in_cmd   = (state == S_ID_CMD) || (state == S_TS_CMD);
    assign in_wait  = (state == S_ID_WAIT) || (state == S_TS_WAIT);
    assign id_phase = (state == S_ID_CMD) || (state == S_ID_WAIT);
    assign accepted = !avm.avm_waitrequest;

    // Data accepted together with the command covers zero-latency slaves
    assign hit  = avm.avm_readdatavalid && ((in_cmd && accepted) || in_wait);
    assign miss = expired && !hit && ((in_cmd && !accepted) || in_wait);

    assign busy            = (state != S_IDLE);
    assign done            = (state == S_FIN);
    assign avm.avm_read    = in_cmd;
    assign avm.avm_address = address;

    assign tmr_en    = in_cmd || in_wait;
    assign tmr_clear = (state_nx != state) &&
                       ((state_nx == S_ID_CMD) || (state_nx == S_TS_CMD));

    sysid_rd_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .expired(expired)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_ID_CMD;
            end
            S_ID_CMD: begin
                if (hit || miss)  state_nx = S_TS_CMD;
                else if (accepted) state_nx = S_ID_WAIT;
            end
            S_ID_WAIT: begin
                if (hit || miss) state_nx = S_TS_CMD;
            end
            S_TS_CMD: begin
                if (hit || miss)  state_nx = S_FIN;
                else if (accepted) state_nx = S_TS_WAIT;
            end
            S_TS_WAIT: begin
                if (hit || miss) state_nx = S_FIN;
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            address     <= 1'b0;
            id_to       <= 1'b0;
            ts_to       <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
        end else begin
            state <= state_nx;
            if (tmr_clear) address <= (state_nx == S_TS_CMD);
            if ((state == S_IDLE) && start) begin
                id_ok       <= 1'b0;
                ts_ok       <= 1'b0;
                timeout_err <= 1'b0;
                id_to       <= 1'b0;
                ts_to       <= 1'b0;
            end
            if (hit && id_phase)  id_value <= avm.avm_readdata;
            if (hit && !id_phase) ts_value <= avm.avm_readdata;
            if (miss) begin
                timeout_err <= 1'b1;
                if (id_phase) id_to <= 1'b1;
                else          ts_to <= 1'b1;
            end
            if (state == S_FIN) begin
                id_ok <= !id_to && (id_value == EXPECTED_ID);
                ts_ok <= !ts_to && (ts_value == EXPECTED_TIMESTAMP);
            end
        end
    end

endmodule

// File: tb/tb_sysid_check_sequencer.sv
// Directed bench: behavioural Avalon slave with configurable wait
// states, read latency, dropped responses and stray readdatavalid.
module tb_sysid_check_sequencer;

    localparam logic [31:0] EXP_ID = 32'h0000_0001;
    localparam logic [31:0] EXP_TS = 32'h5302_A009;
    localparam logic [31:0] BAD_TS = 32'h5302_A008;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int checks = 0;
    int errors = 0;

    // slave configuration
    int          wait_n  = 0;
    int          lat     = 1;
    logic [31:0] id_data = EXP_ID;
    logic [31:0] ts_data = EXP_TS;
    bit          drop_ts = 1'b0;
    bit          inject  = 1'b0;

    // slave state
    int          wcnt      = 0;
    bit          pend      = 1'b0;
    int          pend_cnt  = 0;
    logic [31:0] pend_data = '0;

    // per-cycle trace of the last run_seq
    logic       rd_tr [0:100];
    logic       ad_tr [0:100];
    logic       wr_tr [0:100];
    logic       bz_tr [0:100];
    logic [2:0] fl_tr [0:100];

    sysid_check_sequencer_if avm();

    sysid_check_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .id_ok      (id_ok),
        .ts_ok      (ts_ok),
        .timeout_err(timeout_err),
        .id_value   (id_value),
        .ts_value   (ts_value),
        .avm        (avm)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        #2;
        avm.avm_waitrequest   = 1'b0;
        avm.avm_readdatavalid = 1'b0;
        if (reset) begin
            wcnt = 0;
            pend = 1'b0;
            avm.avm_readdata = '0;
        end else begin
            if (pend) begin
                if (pend_cnt == 0) begin
                    avm.avm_readdatavalid = 1'b1;
                    avm.avm_readdata      = pend_data;
                    pend                  = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
            if (avm.avm_read) begin
                if (wcnt < wait_n) begin
                    avm.avm_waitrequest = 1'b1;
                    wcnt++;
                end else begin
                    wcnt = 0;
                    if (!(drop_ts && avm.avm_address)) begin
                        if (lat == 0) begin
                            avm.avm_readdatavalid = 1'b1;
                            avm.avm_readdata = avm.avm_address ? ts_data : id_data;
                        end else begin
                            pend      = 1'b1;
                            pend_cnt  = lat - 1;
                            pend_data = avm.avm_address ? ts_data : id_data;
                        end
                    end
                end
            end
            if (inject) begin
                avm.avm_readdatavalid = 1'b1;
                avm.avm_readdata      = 32'hDEAD_BEEF;
            end
        end
    end

    // Pulses start and returns the number of cycles until done is seen
    task automatic run_seq(input int restart_at, input int inject_at, output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        @(negedge clock);
        start = 1'b1;
        while (!got && (n < 100)) begin
            @(negedge clock);
            n++;
            start = (n == restart_at);
            if (n == inject_at) inject = 1'b1;
            rd_tr[n] = avm.avm_read;
            ad_tr[n] = avm.avm_address;
            wr_tr[n] = avm.avm_waitrequest;
            bz_tr[n] = busy;
            fl_tr[n] = {id_ok, ts_ok, timeout_err};
            if (done === 1'b1) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            errors++;
            $display("FAIL run_seq: done not seen within %0d cycles", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, id_ok, ts_ok, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00000",
                     {busy, done, id_ok, ts_ok, timeout_err});
        end
        checks++;
        if ({avm.avm_read, avm.avm_address} !== 2'b00) begin
            errors++;
            $display("FAIL reset_bus: got %b expected 00", {avm.avm_read, avm.avm_address});
        end
        checks++;
        if ({id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL reset_values: got %h expected 0", {id_value, ts_value});
        end
        reset = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_zero_wait();
        int n;
        wait_n = 0; lat = 1; ts_data = EXP_TS;
        run_seq(0, 0, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL zero_wait_latency: got %0d expected 5", n);
        end
        checks++;
        if ({rd_tr[1], ad_tr[1], rd_tr[3], ad_tr[3]} !== 4'b1011) begin
            errors++;
            $display("FAIL zero_wait_cmd: got %b expected 1011",
                     {rd_tr[1], ad_tr[1], rd_tr[3], ad_tr[3]});
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err, busy} !== 4'b1100) begin
            errors++;
            $display("FAIL zero_wait_flags: got %b expected 1100",
                     {id_ok, ts_ok, timeout_err, busy});
        end
        checks++;
        if (id_value !== EXP_ID || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL zero_wait_values: got %h %h expected %h %h",
                     id_value, ts_value, EXP_ID, EXP_TS);
        end
    endtask

    task automatic test_zero_latency();
        int n;
        wait_n = 0; lat = 0;
        run_seq(0, 0, n);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL zero_latency_cycles: got %0d expected 3", n);
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b110) begin
            errors++;
            $display("FAIL zero_latency_flags: got %b expected 110", {id_ok, ts_ok, timeout_err});
        end
    endtask

    task automatic test_wait_states();
        int n;
        int waited;
        wait_n = 3; lat = 2;
        run_seq(0, 0, n);
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL wait_cycles: got %0d expected 13", n);
        end
        waited = 0;
        for (int k = 1; k < n; k++) begin
            if (wr_tr[k] === 1'b1 && rd_tr[k] === 1'b1) begin
                waited++;
                checks++;
                if (rd_tr[k+1] !== 1'b1 || ad_tr[k+1] !== ad_tr[k]) begin
                    errors++;
                    $display("FAIL wait_stable cycle %0d: got rd=%b ad=%b expected rd=1 ad=%b",
                             k + 1, rd_tr[k+1], ad_tr[k+1], ad_tr[k]);
                end
            end
        end
        checks++;
        if (waited != 6) begin
            errors++;
            $display("FAIL wait_count: got %0d expected 6", waited);
        end
        checks++;
        if ({rd_tr[5], ad_tr[5], rd_tr[7], ad_tr[7]} !== 4'b0011) begin
            errors++;
            $display("FAIL wait_bus: got %b expected 0011",
                     {rd_tr[5], ad_tr[5], rd_tr[7], ad_tr[7]});
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b110 || id_value !== EXP_ID || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL wait_result: got %b %h %h expected 110 %h %h",
                     {id_ok, ts_ok, timeout_err}, id_value, ts_value, EXP_ID, EXP_TS);
        end
        wait_n = 0; lat = 1;
    endtask

    task automatic test_bad_ts();
        int n;
        ts_data = BAD_TS;
        run_seq(0, 0, n);
        checks++;
        if (fl_tr[1] !== 3'b000) begin
            errors++;
            $display("FAIL bad_ts_clear: got %b expected 000", fl_tr[1]);
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL bad_ts_cycles: got %0d expected 5", n);
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b100 || ts_value !== BAD_TS) begin
            errors++;
            $display("FAIL bad_ts_result: got %b %h expected 100 %h",
                     {id_ok, ts_ok, timeout_err}, ts_value, BAD_TS);
        end
    endtask

    task automatic test_timeout();
        int n;
        ts_data = EXP_TS;
        drop_ts = 1'b1;
        run_seq(0, 18, n);
        checks++;
        if (n != 19) begin
            errors++;
            $display("FAIL timeout_cycles: got %0d expected 19", n);
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b101) begin
            errors++;
            $display("FAIL timeout_flags: got %b expected 101", {id_ok, ts_ok, timeout_err});
        end
        repeat (2) @(negedge clock);
        checks++;
        if (id_value !== EXP_ID || ts_value !== BAD_TS || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_late_data: got %h %h busy=%b expected %h %h busy=0",
                     id_value, ts_value, busy, EXP_ID, BAD_TS);
        end
        inject  = 1'b0;
        drop_ts = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        run_seq(2, 0, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_busy_start: got %0d expected 5", n);
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || {id_ok, ts_ok, timeout_err} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_done_start: got busy=%b flags=%b expected busy=0 flags=110",
                     busy, {id_ok, ts_ok, timeout_err});
        end
        repeat (2) @(negedge clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_not_queued: got busy=%b expected 0", busy);
        end
        run_seq(0, 0, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL b2b_idle_start: got %0d expected 5", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int done_seen;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, avm.avm_read, avm.avm_address} !== 3'b101) begin
            errors++;
            $display("FAIL mid_ts_wait: got %b expected 101", {busy, avm.avm_read, avm.avm_address});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, id_ok, ts_ok, timeout_err, avm.avm_read, avm.avm_address} !== 7'b0
            || {id_value, ts_value} !== 64'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got %b %h %h expected all zero",
                     {busy, done, id_ok, ts_ok, timeout_err, avm.avm_read, avm.avm_address},
                     id_value, ts_value);
        end
        done_seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (done !== 1'b0) done_seen++;
        end
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (done !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d done cycles expected 0", done_seen);
        end
        run_seq(0, 0, n);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL mid_rerun_cycles: got %0d expected 5", n);
        end
        @(negedge clock);
        checks++;
        if ({id_ok, ts_ok, timeout_err} !== 3'b110 || id_value !== EXP_ID || ts_value !== EXP_TS) begin
            errors++;
            $display("FAIL mid_rerun_result: got %b %h %h expected 110 %h %h",
                     {id_ok, ts_ok, timeout_err}, id_value, ts_value, EXP_ID, EXP_TS);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_zero_latency();
        test_wait_states();
        test_bad_ts();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sysid_check_sequencer.md
SYSID_CHECK_SEQUENCER -- requirements
Module: sysid_check_sequencer

Interface
REQ-001 SHALL have parameter EXPECTED_ID, default 32'h0000_0001, the system ID value the hardware must report.
REQ-002 SHALL have parameter EXPECTED_TIMESTAMP, default 32'h5302_A009, the build timestamp the hardware must report.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, the maximum cycles allowed per read transaction, range 2..255.
REQ-004 SHALL have port clock, input, 1, the single clock; every flop is in this domain.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, a single-cycle request to run one check sequence.
REQ-007 SHALL have port busy, output, 1, high while a sequence is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when a sequence ends.
REQ-009 SHALL have port id_ok, output, 1, set when the captured ID equals EXPECTED_ID.
REQ-010 SHALL have port ts_ok, output, 1, set when the captured timestamp equals EXPECTED_TIMESTAMP.
REQ-011 SHALL have port timeout_err, output, 1, set when any read in the sequence timed out.
REQ-012 SHALL have port id_value, output, 32, the captured ID word.
REQ-013 SHALL have port ts_value, output, 32, the captured timestamp word.
REQ-014 SHALL have Avalon-MM master ports: avm_address out 1, avm_read out 1, avm_waitrequest in 1, avm_readdata in 32, avm_readdatavalid in 1.

Function
REQ-015 SHALL implement the FSM IDLE -> ID_CMD -> ID_WAIT -> TS_CMD -> TS_WAIT -> FIN -> IDLE.
REQ-016 IDLE SHALL, on start=1, clear id_ok, ts_ok and timeout_err, then enter ID_CMD on the next cycle.
REQ-017 ID_CMD SHALL drive avm_read=1 and avm_address=0, and hold both stable until a cycle in which avm_waitrequest=0, then enter ID_WAIT.
REQ-018 ID_WAIT SHALL capture avm_readdata into id_value on the cycle avm_readdatavalid=1, then enter TS_CMD.
REQ-019 If avm_readdatavalid=1 in the same cycle the command is accepted, the FSM SHALL capture that data and skip the wait state (zero-latency slave).
REQ-020 TS_CMD and TS_WAIT SHALL behave the same as ID_CMD and ID_WAIT, using avm_address=1 and capturing into ts_value.
REQ-021 An 8-bit per-transaction counter SHALL clear on entry to each CMD state and increment every cycle in the CMD and WAIT states.
REQ-022 When the counter reaches TIMEOUT_CYCLES-1 without the awaited event, the FSM SHALL set timeout_err, deassert avm_read, leave the value register unchanged, and go to the next CMD state or to FIN.
REQ-023 FIN SHALL set id_ok = (id_value == EXPECTED_ID) and ts_ok = (ts_value == EXPECTED_TIMESTAMP), compared over the full 32 bits, forced to 0 if that read timed out; FIN SHALL pulse done for one cycle and then return to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; a start received while busy SHALL be ignored, not queued.
REQ-025 A start in the same cycle that done pulses SHALL be ignored; a start in the following cycle (IDLE) SHALL be accepted.
REQ-026 An avm_readdatavalid arriving in IDLE or FIN, or after a timeout, SHALL be discarded.
REQ-027 avm_read SHALL be 0 outside the CMD states; avm_address SHALL hold its last value when avm_read=0.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE and zero busy, done, id_ok, ts_ok, timeout_err, id_value, ts_value, avm_read, avm_address and the counter.
REQ-029 Reset asserted mid-sequence SHALL abort the sequence without a done pulse; the first start after reset releases SHALL run a full sequence.

Structure
REQ-030 The FSM state enum and the default expected constants SHALL live in the shared package sysid_pkg.
REQ-031 The design SHALL use one sub-module, sysid_rd_timer, holding the per-transaction timeout counter; everything else is flat.

Verification
REQ-032 Zero-wait slave (ID 1, TS 32'h5302_A009), pulse start -> done 5 cycles later, id_ok=1, ts_ok=1, timeout_err=0.
REQ-033 Slave asserts waitrequest 3 cycles per read and gives readdatavalid 2 cycles later -> avm_read/address stay stable while waited, both values are captured, and both ok flags are 1.
REQ-034 Slave returns TS 32'h5302_A008 -> id_ok=1, ts_ok=0, ts_value=32'h5302_A008.
REQ-035 Slave never returns readdatavalid for address 1 -> timeout_err=1 and ts_ok=0 after TIMEOUT_CYCLES; done still pulses; a late readdatavalid is ignored.
REQ-036 Second start during busy, then reset asserted in TS_WAIT -> the second start has no effect; on reset all outputs are 0 at once with no done; a start after release yields a normal pass.
